// File: rtl/timer_if.sv
// Register-bus bundle between the system bridge and timer_counter.
// The bridge drives the access; the timer returns read data and its interrupt line.
interface timer_if;
  logic        sel;
  logic [1:0]  addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output sel, addr, byteen, wdata, input rdata, irq);
  modport slave  (input sel, addr, byteen, wdata, output rdata, irq);
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer: CTRL/PRESET/COUNT, one-shot (held irq) or auto-reload (pulsed irq).
// Define TIMER_PRESCALER_EN to implement the CTRL[15:8] tick prescaler.
module timer_counter #(
  parameter int COUNT_W = 32
) (
  input  logic   clk,
  input  logic   reset,
  timer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CNT  = 2'd1,
    INT  = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  state_t             state;
  logic               ctrl_en;
  logic [1:0]         ctrl_mode;
  logic               ctrl_im;
  logic [7:0]         ctrl_ps;
  logic [COUNT_W-1:0] preset;
  logic [COUNT_W-1:0] count;
  logic               flag;

  logic wr;
  logic wr_ctrl;
  logic wr_preset;
  logic auto_reload;
  logic tick;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  lanes);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++)
      if (lanes[i]) res[8*i +: 8] = new_word[8*i +: 8];
    return res;
  endfunction

  assign wr          = bus.sel && (bus.byteen != 4'b0000);
  assign wr_ctrl     = wr && (bus.addr == ADDR_CTRL);
  assign wr_preset   = wr && (bus.addr == ADDR_PRESET);
  assign auto_reload = (ctrl_mode == 2'b01);

`ifdef TIMER_PRESCALER_EN
  logic [7:0] ps_cnt;
  logic       ps_load;
  logic       counting;

  assign ps_load  = ((state == IDLE) && ctrl_en) || ((state == INT) && auto_reload);
  assign counting = (state == CNT) && ctrl_en && (count != '0);
  // >= rather than == so lowering PS below the running count cannot stall the tick.
  assign tick     = (ps_cnt >= ctrl_ps);

  always_ff @(posedge clk) begin
    if (!reset || ps_load) ps_cnt <= '0;
    else if (counting)     ps_cnt <= tick ? 8'd0 : ps_cnt + 8'd1;
  end
`else
  assign ctrl_ps = 8'd0;
  assign tick    = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments; the software writes come after the
  // FSM in this block on purpose, so the later assignment wins when both touch EN or FLAG.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      ctrl_en   <= 1'b0;
      ctrl_mode <= 2'b00;
      ctrl_im   <= 1'b0;
`ifdef TIMER_PRESCALER_EN
      ctrl_ps   <= 8'd0;
`endif
      preset    <= '0;
      count     <= '0;
      flag      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ctrl_en) begin
            count <= preset;
            state <= CNT;
          end
        end
        CNT: begin
          if (!ctrl_en) begin
            state <= IDLE;
          end else if (count == '0) begin
            flag  <= 1'b1;
            state <= INT;
          end else if (tick) begin
            count <= count - COUNT_W'(1);
          end
        end
        INT: begin
          if (auto_reload) begin
            flag  <= 1'b0;
            count <= preset;
            state <= CNT;
          end else begin
            ctrl_en <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (wr_ctrl) begin
        if (bus.byteen[0]) {ctrl_im, ctrl_mode, ctrl_en} <= bus.wdata[3:0];
`ifdef TIMER_PRESCALER_EN
        if (bus.byteen[1]) ctrl_ps <= bus.wdata[15:8];
`endif
      end
      if (wr_preset)
        preset <= COUNT_W'(merge_lanes(32'(preset), bus.wdata, bus.byteen));
      if (wr_ctrl || wr_preset)
        flag <= 1'b0;
    end
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      ADDR_CTRL:   bus.rdata = {16'd0, ctrl_ps, 4'd0, ctrl_im, ctrl_mode, ctrl_en};
      ADDR_PRESET: bus.rdata = 32'(preset);
      ADDR_COUNT:  bus.rdata = 32'(count);
      default:     bus.rdata = '0;
    endcase
  end

  assign bus.irq = flag && ctrl_im;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: register table, directed timing sequences,
// and randomized traffic against a behavioural model.
module tb_timer_counter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  timer_if bus ();

  timer_counter #(.COUNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef TIMER_PRESCALER_EN
  localparam logic [31:0] CTRL_MASK = 32'h0000_FF0F;
`else
  localparam logic [31:0] CTRL_MASK = 32'h0000_000F;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.sel    = 1'b0;
    bus.addr   = 2'd0;
    bus.byteen = 4'b0000;
    bus.wdata  = 32'd0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
    bus.sel    = 1'b1;
    bus.addr   = a;
    bus.byteen = be;
    bus.wdata  = d;
    step();
    idle_bus();
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    bus.sel    = 1'b1;
    bus.addr   = a;
    bus.byteen = 4'b0000;
    #1;
    check(name, bus.rdata, exp);
  endtask

  task automatic irq_check(input string name, input logic exp);
    check(name, {31'd0, bus.irq}, {31'd0, exp});
  endtask

  task automatic do_reset();
    idle_bus();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_ctrl, m_preset, m_count;
  logic        m_flag, m_running, m_expired;
  int          m_ps;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return m_ctrl;
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = 0; m_preset = 0; m_count = 0;
    m_flag = 0; m_running = 0; m_expired = 0; m_ps = 0;
  endtask

  task automatic model_edge(input logic rst_n, input logic s, input logic [1:0] a,
                            input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] nctrl, npreset, ncount;
    logic        nflag, nrun, nexp, we;
    int          nps, ps_lim;
    if (!rst_n) begin
      model_reset();
      return;
    end
    nctrl = m_ctrl; npreset = m_preset; ncount = m_count;
    nflag = m_flag; nrun = m_running; nexp = m_expired; nps = m_ps;
    ps_lim = int'(m_ctrl[15:8]);
    if (!m_running) begin
      if (m_ctrl[0]) begin ncount = m_preset; nrun = 1; nps = 0; end
    end else if (m_expired) begin
      nexp = 0;
      if (m_ctrl[2:1] == 2'b01) begin nflag = 0; ncount = m_preset; nps = 0; end
      else begin nrun = 0; nctrl[0] = 1'b0; end
    end else if (!m_ctrl[0]) begin
      nrun = 0;
    end else if (m_count == 0) begin
      nexp = 1; nflag = 1;
    end else if (m_ps >= ps_lim) begin
      ncount = m_count - 1; nps = 0;
    end else begin
      nps = m_ps + 1;
    end
    we = s && (be != 4'b0000);
    if (we && a == 2'd0) nctrl = lane_merge(nctrl, wd, be) & CTRL_MASK;
    if (we && a == 2'd1) npreset = lane_merge(m_preset, wd, be);
    if (we && (a == 2'd0 || a == 2'd1)) nflag = 0;
    m_ctrl = nctrl; m_preset = npreset; m_count = ncount;
    m_flag = nflag; m_running = nrun; m_expired = nexp; m_ps = nps;
  endtask

  // ---------------- register-access table ----------------
  typedef struct {
    string       name;
    logic        sel;
    logic [1:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  rd_addr;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic s, input logic [1:0] a,
                              input logic [3:0] be, input logic [31:0] d,
                              input logic [1:0] ra, input logic [31:0] er);
    vec_t v;
    v.name = n; v.sel = s; v.addr = a; v.be = be; v.wdata = d;
    v.rd_addr = ra; v.exp_rdata = er; v.exp_irq = 1'b0;
    return v;
  endfunction

  initial begin
    logic [31:0] ctrl_all;
    ctrl_all = 32'hFFFF_FF0E & CTRL_MASK;
    vecs.push_back(mk("preset_full",   1, 2'd1, 4'hF, 32'h1234_5678, 2'd1, 32'h1234_5678));
    vecs.push_back(mk("preset_lane02", 1, 2'd1, 4'h5, 32'hAABB_CCDD, 2'd1, 32'h12BB_56DD));
    vecs.push_back(mk("preset_lane13", 1, 2'd1, 4'hA, 32'h00FF_00FF, 2'd1, 32'h00BB_00DD));
    vecs.push_back(mk("count_ro",      1, 2'd2, 4'hF, 32'hFFFF_FFFF, 2'd2, 32'h0000_0000));
    vecs.push_back(mk("reserved",      1, 2'd3, 4'hF, 32'hFFFF_FFFF, 2'd3, 32'h0000_0000));
    vecs.push_back(mk("ctrl_impl",     1, 2'd0, 4'hF, 32'hFFFF_FF0E, 2'd0, ctrl_all));
    vecs.push_back(mk("ctrl_nosel",    0, 2'd0, 4'hF, 32'h0000_0001, 2'd0, ctrl_all));
    vecs.push_back(mk("ctrl_lane1",    1, 2'd0, 4'h2, 32'h0000_0000, 2'd0, 32'h0000_000E));
    vecs.push_back(mk("ctrl_lane0",    1, 2'd0, 4'h1, 32'h0000_0000, 2'd0, 32'h0000_0000));
    vecs.push_back(mk("preset_no_be",  1, 2'd1, 4'h0, 32'hFFFF_FFFF, 2'd1, 32'h00BB_00DD));

    // Reset state
    reset = 1'b0;
    idle_bus();
    step();
    step();
    reset = 1'b1;
    for (int a = 0; a < 4; a++) rd_check($sformatf("reset_rd%0d", a), 2'(a), 32'd0);
    irq_check("reset_irq", 1'b0);
    idle_bus();

    // Table-driven register access
    foreach (vecs[i]) begin
      bus.sel = vecs[i].sel; bus.addr = vecs[i].addr;
      bus.byteen = vecs[i].be; bus.wdata = vecs[i].wdata;
      step();
      idle_bus();
      rd_check(vecs[i].name, vecs[i].rd_addr, vecs[i].exp_rdata);
      irq_check({vecs[i].name, "_irq"}, vecs[i].exp_irq);
    end

    // One-shot: PRESET=3, CTRL=0x9
    do_reset();
    wr(2'd1, 4'hF, 32'd3);
    wr(2'd0, 4'hF, 32'h9);
    for (int k = 1; k <= 4; k++) begin
      step();
      rd_check($sformatf("oneshot_count_t%0d", k), 2'd2, 32'(4 - k));
      irq_check($sformatf("oneshot_noirq_t%0d", k), 1'b0);
    end
    step();
    irq_check("oneshot_irq_t5", 1'b1);
    step();
    rd_check("oneshot_ctrl_t6", 2'd0, 32'h8);
    irq_check("oneshot_irq_held_t6", 1'b1);
    step();
    irq_check("oneshot_irq_held_t7", 1'b1);
    wr(2'd0, 4'hF, 32'h0);
    irq_check("oneshot_irq_cleared", 1'b0);
    step();
    irq_check("oneshot_irq_stays_low", 1'b0);

    // Auto-reload: PRESET=2 gives a 4-cycle period
    do_reset();
    wr(2'd1, 4'hF, 32'd2);
    wr(2'd0, 4'hF, 32'hB);
    for (int k = 1; k <= 16; k++) begin
      step();
      irq_check($sformatf("reload_irq_t%0d", k), (k >= 4) && (k % 4 == 0));
    end
    do_reset();
    wr(2'd1, 4'hF, 32'd2);
    wr(2'd0, 4'hF, 32'h3);
    for (int k = 1; k <= 16; k++) begin
      step();
      irq_check($sformatf("reload_masked_t%0d", k), 1'b0);
      if (k == 5) rd_check("reload_masked_count_t5", 2'd2, 32'd2);
    end

    // PRESET=0 and byte-lane PRESET write clearing the held flag
    do_reset();
    wr(2'd1, 4'hF, 32'd0);
    wr(2'd0, 4'hF, 32'h9);
    step();
    irq_check("zero_preset_t1", 1'b0);
    step();
    irq_check("zero_preset_t2", 1'b1);
    wr(2'd1, 4'b0001, 32'h0000_00FF);
    irq_check("zero_preset_cleared", 1'b0);
    rd_check("zero_preset_new", 2'd1, 32'h0000_00FF);

    // Reset mid-count
    do_reset();
    wr(2'd1, 4'hF, 32'd10);
    wr(2'd0, 4'hF, 32'h9);
    for (int k = 0; k < 6; k++) step();
    rd_check("midreset_pre_count", 2'd2, 32'd5);
    idle_bus();
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int a = 0; a < 4; a++) rd_check($sformatf("midreset_rd%0d", a), 2'(a), 32'd0);
    idle_bus();
    for (int k = 0; k < 15; k++) begin
      step();
      irq_check($sformatf("midreset_noirq_%0d", k), 1'b0);
    end

    // EN cleared mid-count: the count freezes
    do_reset();
    wr(2'd1, 4'hF, 32'd10);
    wr(2'd0, 4'hF, 32'h9);
    for (int k = 0; k < 5; k++) step();
    rd_check("enclr_pre_count", 2'd2, 32'd6);
    wr(2'd0, 4'hF, 32'h0);
    rd_check("enclr_count", 2'd2, 32'd5);
    for (int k = 0; k < 3; k++) begin
      step();
      rd_check($sformatf("enclr_hold_%0d", k), 2'd2, 32'd5);
    end

`ifdef TIMER_PRESCALER_EN
    // Prescaler: PS=2, PRESET=2, one-shot
    do_reset();
    wr(2'd1, 4'hF, 32'd2);
    wr(2'd0, 4'hF, 32'h0209);
    for (int k = 1; k <= 7; k++) begin
      step();
      rd_check($sformatf("ps_count_t%0d", k), 2'd2, (k <= 3) ? 32'd2 : (k <= 6) ? 32'd1 : 32'd0);
      irq_check($sformatf("ps_noirq_t%0d", k), 1'b0);
    end
    step();
    irq_check("ps_irq_t8", 1'b1);
`endif

    // Randomized traffic against the model
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic        rst_n, s;
      logic [1:0]  a;
      logic [3:0]  be;
      logic [31:0] wd;
      int          r;
      rst_n = ($urandom_range(0, 299) != 0);
      r  = int'($urandom_range(0, 99));
      s  = 1'b1;
      be = 4'($urandom_range(1, 15));
      wd = $urandom();
      if (r < 8) begin
        a = 2'd0;
        wd[15:8] = 8'($urandom_range(0, 3));
        wd[0]    = ($urandom_range(0, 3) != 0);
      end else if (r < 14) begin
        a = 2'd1;
        if ($urandom_range(0, 7) != 0) wd = 32'($urandom_range(0, 8));
      end else if (r < 17) begin
        a = 2'($urandom_range(2, 3));
      end else begin
        a  = 2'($urandom_range(0, 3));
        be = 4'b0000;
        s  = ($urandom_range(0, 9) != 0);
      end
      reset = rst_n; bus.sel = s; bus.addr = a; bus.byteen = be; bus.wdata = wd;
      #1;
      if (s) check("rand_rdata", bus.rdata, model_read(a));
      irq_check("rand_irq", m_flag && m_ctrl[3]);
      model_edge(rst_n, s, a, be, wd);
      step();
    end
    reset = 1'b1;
    idle_bus();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped 32-bit down-counting timer that sits downstream of the CPU data-memory port, behind the system bridge. It decodes word writes and reads issued through the CPU's data address, write data and byte-enable outputs, and raises an interrupt line that the bridge routes back into the CPU's `HWInt` vector. It supports two modes: one-shot with a held interrupt, and auto-reload with a one-cycle pulse.

## Interface
- `COUNT_W`, 32, width of PRESET/COUNT registers (≤32; unused upper read bits are 0)
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-low reset (reset asserted when 0)
- `sel`  in  1  chip select from bridge; access ignored when 0
- `addr`  in  2  word select (data address bits [3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
- `byteen`  in  4  byte write enables; write occurs when `sel` & `byteen`≠0
- `wdata`  in  32  write data
- `rdata`  out  32  read data, combinational from current register state
- `irq`  out  1  interrupt request, one bit of `HWInt`

## Operation
- CTRL layout:
  - [0] EN
  - [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00)
  - [3] IM (interrupt mask)
  - [15:8] PS (see Configuration)
  - all other bits read 0
- PRESET: read/write. COUNT: read-only; writes are ignored.
- Byte writes merge per `byteen` lane; only implemented bits change.
- Reserved address: reads return 0, writes are ignored.
- `irq` = FLAG & IM. FLAG is internal and not software-visible.
- FSM states IDLE, CNT, INT:
  - IDLE: if EN=1, next edge COUNT←PRESET and go to CNT.
  - CNT: if EN=0, go to IDLE with COUNT held. Else if COUNT==0, go to INT and set FLAG. Else decrement COUNT on each tick.
  - INT, MODE 00: next edge EN←0, go to IDLE; FLAG stays set until software writes CTRL or PRESET.
  - INT, MODE 01: next edge FLAG←0, COUNT←PRESET, go to CNT.
- PRESET=0: CNT goes directly to INT on the next edge.
- Any write to CTRL or PRESET clears FLAG on that edge.
- Simultaneous events: a software CTRL write overrides the FSM's EN←0 in INT. A FLAG clear by write overrides a FLAG set in the same cycle.
- Writing PRESET during CNT does not affect the current COUNT; it takes effect at the next load.

## Timing
- Reset (reset=0 at an edge): CTRL=0, PRESET=0, COUNT=0, FLAG=0, state IDLE. Outputs after reset: `irq`=0; `rdata` reflects the zeroed registers.
- Writes take effect at the edge where they are presented. Reads have zero latency, so the CPU captures them in the same MEM cycle.
- One-shot with EN written at edge t: COUNT=PRESET after t+1, decrements through t+1+PRESET, state INT and `irq` high after t+2+PRESET.
- Auto-reload: interrupt period is PRESET+2 cycles. `irq` is high for exactly 1 cycle per period when IM=1.
- Asserting reset mid-count aborts immediately; no interrupt is produced.

## Configuration
- `TIMER_PRESCALER_EN` defined:
  - CTRL[15:8] PS is implemented.
  - In CNT, a tick occurs once every PS+1 cycles, using an internal prescale counter.
  - The prescale counter clears on load, reload and reset.
  - The COUNT==0 check is performed every cycle, not only on ticks.
- `TIMER_PRESCALER_EN` undefined: PS is not implemented and reads 0; a tick occurs every cycle.

## Test plan
- Reset held 0 for 2 cycles, then read all addresses → `rdata`=0 for every address, `irq`=0.
- PRESET=3, then CTRL=0x9 (EN, IM, mode 0) at edge t → COUNT reads 3,2,1,0 after t+1..t+4; `irq`=1 after t+5 and held; CTRL reads 0x8 after t+6. A write of CTRL=0 then drops `irq` the next cycle.
- PRESET=2, CTRL=0xB (auto-reload) → `irq` pulses 1 cycle every 4 cycles for ≥3 periods. With CTRL=0x3 (IM=0), `irq` stays 0.
- PRESET=0, CTRL=0x9 → `irq`=1 two cycles after the write. A byteen=4'b0001 write of 0xFF to PRESET changes PRESET to 0xFF and clears `irq`.
- Mid-count (COUNT=5), reset=0 for 1 cycle → all registers 0, state IDLE, no `irq`. The same scenario with EN cleared instead → COUNT holds at 5.
- With `TIMER_PRESCALER_EN`: PS=2, PRESET=2, one-shot → COUNT decrements every 3 cycles, and `irq` rises 1 cycle after COUNT reaches 0.
